pqvalue_ntt_ctrl: RTL and testbench
===================================

# pqvalue_ntt_ctrl

Sequencer that drives the single-cycle `pqvalue_top` butterfly through a complete 256-point in-place NTT (forward, Cooley-Tukey) or inverse NTT (Gentleman-Sande) for Dilithium or Kyber. It produces coefficient-RAM read/write addresses and twiddle-ROM addresses, and routes RAM data into the butterfly and butterfly results back to RAM. It sits between the coprocessor command logic (`start_i` / `done_o`) and the coefficient memory. The inverse transform's final n^-1 scaling is done downstream, not in this block.

## Interface
- N, 256, transform length; only 256 supported
- LOGN, 8, log2(N); sets the address width
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  start request; sampled only in IDLE
- mode_i  in  1  0 forward CT, 1 inverse GS; latched at start
- sel_red_i  in  1  0 Dilithium, 1 Kyber; latched at start
- busy_o  out  1  high from accepted start through DONE
- done_o  out  1  one-cycle completion pulse
- rd_en_o  out  1  coefficient RAM read strobe; data returns next cycle
- rd_addr_a_o, rd_addr_b_o  out  LOGN  read addresses j, j+len
- rd_data_a_i, rd_data_b_i  in  24  read data, one cycle after rd_en_o
- tw_addr_o  out  LOGN  twiddle ROM address k; ROM data valid next cycle
- tw_data_i  in  23  twiddle data
- wr_en_o  out  1  coefficient RAM write strobe
- wr_addr_a_o, wr_addr_b_o  out  LOGN  write addresses (read addresses delayed one cycle)
- wr_data_a_o, wr_data_b_o  out  24  {1'b0, bf_a_i}, {1'b0, bf_b_i}
- bf_a_o, bf_b_o  out  24  butterfly operands (rd_data passed through)
- bf_twiddle_o  out  23  tw_data_i passed through
- bf_sel_red_o, bf_sel_butterfly_o  out  1  latched sel_red / mode
- bf_a_i, bf_b_i  in  23  butterfly results

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: when start_i=1, latch mode and sel_red, clear layer l and butterfly counter c, go to RUN. busy_o rises in the next cycle.
- RUN: issue one butterfly per cycle, c = 0..127. Assert rd_en_o and drive addresses for c. After c=127, go to DRAIN.
- DRAIN: one cycle with no read issued. The last write of the layer lands in this cycle.
  - If this is the last layer, go to DONE.
  - Otherwise increment l, clear c, and go to RUN.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Layer count L: 8 for Dilithium, 7 for Kyber. l runs 0..L-1.
- Butterfly span len:
  - forward: 128>>l
  - inverse Dilithium: 1<<l
  - inverse Kyber: 2<<l
  - let s = log2(len)
- Addressing: group g = c>>s, offset o = c & (len-1), j = (g<<(s+1)) + o. rd_addr_a = j, rd_addr_b = j+len.
- Twiddle address:
  - forward: k = (1<<l) + g
  - inverse: k = (Kmax>>l) - 1 - g, where Kmax = 256 for Dilithium and 128 for Kyber
  - twiddle sign for the inverse transform is encoded in the ROM contents
- Write stage: a registered copy of rd_en and the addresses, delayed one cycle, gives wr_en_o and wr_addr. Write data is combinational from bf_a_i/bf_b_i in that same cycle.
- start_i while busy is ignored. mode_i and sel_red_i changes while busy have no effect.
- Reset (any time, including mid-transform) puts the FSM in IDLE and zeros every output and counter. No partial write is issued after reset is released.

## Timing
- Reset values: busy_o, done_o, rd_en_o, wr_en_o, bf_sel_* = 0; all addresses and data = 0.
- Count cycles from the edge that accepts start (cycle 0):
  - first read in cycle 1
  - layer period 129 cycles (128 RUN + 1 DRAIN)
- Dilithium: last write in cycle 1032, done_o in cycle 1033, busy_o high in cycles 1..1033.
- Kyber: last write in cycle 903, done_o in cycle 904.
- Read-to-write latency: 1 cycle. Write in cycle t+1 for the read issued in cycle t.
- DRAIN guarantees that a read of layer l+1 never coincides with a write of layer l.
- rd_en_o and wr_en_o overlap inside RUN. They touch disjoint address pairs within a layer.

## Test plan
- Reset: hold rst_ni=0 with random inputs -> all outputs 0. Release and pulse rst_ni low mid-RUN (cycle 300) -> outputs zero immediately, no wr_en_o afterwards, next start runs a full transform.
- Dilithium forward: start with mode=0, sel=0 ->
  - cycle 1: addrs (0,128), tw=1
  - cycle 130: (0,64), tw=2
  - cycle 194: (128,192), tw=3
  - done_o in cycle 1033 and 1024 wr_en_o pulses in total
- Kyber inverse: mode=1, sel=1 ->
  - cycle 1: (0,2), tw=127
  - cycle 2: (1,3), tw=127
  - cycle 3: (4,6), tw=126
  - last layer: (j, j+128), tw=1
  - done_o in cycle 904 and 896 writes
- Datapath: stub butterfly returns a+1 and b+2, RAM preloaded with addr value -> first write has wr_addr (0,128) and data (1,130). wr_data bit 23 always 0.
- Busy handling: assert start_i again in cycle 500 and toggle mode_i -> ignored, address sequence unchanged. Start held high continuously -> back-to-back transforms with IDLE for one cycle between done_o and the next accept.
- Exhaustive address check: a scoreboard mirrors the reference loop nest for all four mode/sel combinations and compares every rd_addr and tw_addr.

Source files
------------

// File: rtl/pqvalue_ntt_ctrl.sv
// Sequencer for a 256-point in-place NTT / inverse NTT over a single-cycle butterfly.
// Generates coefficient-RAM and twiddle-ROM addresses and steers data between RAM and butterfly.
module pqvalue_ntt_ctrl #(
  parameter int unsigned N    = 256,
  parameter int unsigned LOGN = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic            sel_red_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_en_o,
  output logic [LOGN-1:0] rd_addr_a_o,
  output logic [LOGN-1:0] rd_addr_b_o,
  input  logic [23:0]     rd_data_a_i,
  input  logic [23:0]     rd_data_b_i,
  output logic [LOGN-1:0] tw_addr_o,
  input  logic [22:0]     tw_data_i,
  output logic            wr_en_o,
  output logic [LOGN-1:0] wr_addr_a_o,
  output logic [LOGN-1:0] wr_addr_b_o,
  output logic [23:0]     wr_data_a_o,
  output logic [23:0]     wr_data_b_o,
  output logic [23:0]     bf_a_o,
  output logic [23:0]     bf_b_o,
  output logic [22:0]     bf_twiddle_o,
  output logic            bf_sel_red_o,
  output logic            bf_sel_butterfly_o,
  input  logic [22:0]     bf_a_i,
  input  logic [22:0]     bf_b_i
);

  localparam int unsigned Half = N / 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      layer_q, layer_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic            sel_q, sel_d;
  logic            wr_en_q;
  logic [LOGN-1:0] wr_addr_a_q, wr_addr_b_q;

  logic            last_layer;
  logic [3:0]      shamt;
  logic [LOGN-1:0] len, grp, ofs, j_addr, k_addr;
  logic [LOGN:0]   k_inv;

  assign last_layer = sel_q ? (layer_q == 3'd6) : (layer_q == 3'd7);

  // Span exponent s: forward halves the span each layer, inverse doubles it.
  always_comb begin
    if (!mode_q) begin
      shamt = 4'd7 - {1'b0, layer_q};
    end else if (sel_q) begin
      shamt = {1'b0, layer_q} + 4'd1;
    end else begin
      shamt = {1'b0, layer_q};
    end
    len    = 8'd1 << shamt;
    grp    = {1'b0, cnt_q} >> shamt;
    ofs    = {1'b0, cnt_q} & (len - 8'd1);
    j_addr = (grp << (shamt + 4'd1)) + ofs;
    k_inv  = ((sel_q ? 9'd128 : 9'd256) >> layer_q) - 9'd1 - {1'b0, grp};
    k_addr = mode_q ? k_inv[LOGN-1:0] : ((8'd1 << layer_q) + grp);
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          sel_d   = sel_red_i;
          layer_d = 3'd0;
          cnt_d   = 7'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(Half - 1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        cnt_d = 7'd0;
        if (last_layer) begin
          state_d = StDone;
        end else begin
          layer_d = layer_q + 3'd1;
          state_d = StRun;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      layer_q     <= 3'd0;
      cnt_q       <= 7'd0;
      mode_q      <= 1'b0;
      sel_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_a_q <= '0;
      wr_addr_b_q <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      wr_en_q     <= rd_en_o;
      wr_addr_a_q <= rd_addr_a_o;
      wr_addr_b_q <= rd_addr_b_o;
    end
  end

  assign busy_o             = (state_q != StIdle);
  assign done_o             = (state_q == StDone);
  assign rd_en_o            = (state_q == StRun);
  assign rd_addr_a_o        = rd_en_o ? j_addr : '0;
  assign rd_addr_b_o        = rd_en_o ? (j_addr + len) : '0;
  assign tw_addr_o          = rd_en_o ? k_addr : '0;
  assign bf_sel_red_o       = sel_q;
  assign bf_sel_butterfly_o = mode_q;

  // Data paths are gated by the write-stage valid so stale RAM/ROM data never leaks out.
  assign wr_en_o      = wr_en_q;
  assign wr_addr_a_o  = wr_addr_a_q;
  assign wr_addr_b_o  = wr_addr_b_q;
  assign bf_a_o       = wr_en_q ? rd_data_a_i : '0;
  assign bf_b_o       = wr_en_q ? rd_data_b_i : '0;
  assign bf_twiddle_o = wr_en_q ? tw_data_i : '0;
  assign wr_data_a_o  = wr_en_q ? {1'b0, bf_a_i} : '0;
  assign wr_data_b_o  = wr_en_q ? {1'b0, bf_b_i} : '0;

endmodule

// File: tb/tb_pqvalue_ntt_ctrl.sv
// Directed bench for pqvalue_ntt_ctrl: RAM/ROM/butterfly stubs plus an address scoreboard
// built from the textbook NTT loop nest.
module tb_pqvalue_ntt_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni, start_i, mode_i, sel_red_i;
  logic        busy_o, done_o, rd_en_o, wr_en_o, bf_sel_red_o, bf_sel_butterfly_o;
  logic [7:0]  rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o;
  logic [23:0] rd_data_a_i, rd_data_b_i, wr_data_a_o, wr_data_b_o, bf_a_o, bf_b_o;
  logic [22:0] tw_data_i, bf_twiddle_o, bf_a_i, bf_b_i, rnd_a, rnd_b;

  logic [23:0] mem [256];
  logic        preload, rnd_in, mon_on, first_chk, bit23;
  int          edge_n = 0, t0 = 0, mc;
  int          n_checks = 0, n_fail = 0;
  int          wr_cnt, last_wr, done_seen, done_cyc, busy_cnt, rd2_cyc;
  logic [23:0] q_exp[$];
  logic [23:0] exp_e;
  int          spot_cyc[$];
  logic [24:0] spot_val[$];

  always #5 clk = ~clk;

  pqvalue_ntt_ctrl dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .start_i            (start_i),
    .mode_i             (mode_i),
    .sel_red_i          (sel_red_i),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .rd_en_o            (rd_en_o),
    .rd_addr_a_o        (rd_addr_a_o),
    .rd_addr_b_o        (rd_addr_b_o),
    .rd_data_a_i        (rd_data_a_i),
    .rd_data_b_i        (rd_data_b_i),
    .tw_addr_o          (tw_addr_o),
    .tw_data_i          (tw_data_i),
    .wr_en_o            (wr_en_o),
    .wr_addr_a_o        (wr_addr_a_o),
    .wr_addr_b_o        (wr_addr_b_o),
    .wr_data_a_o        (wr_data_a_o),
    .wr_data_b_o        (wr_data_b_o),
    .bf_a_o             (bf_a_o),
    .bf_b_o             (bf_b_o),
    .bf_twiddle_o       (bf_twiddle_o),
    .bf_sel_red_o       (bf_sel_red_o),
    .bf_sel_butterfly_o (bf_sel_butterfly_o),
    .bf_a_i             (bf_a_i),
    .bf_b_i             (bf_b_i)
  );

  // Stub butterfly: a+1, b+2 (random while rnd_in is set).
  assign bf_a_i = rnd_in ? rnd_a : (bf_a_o[22:0] + 23'd1);
  assign bf_b_i = rnd_in ? rnd_b : (bf_b_o[22:0] + 23'd2);

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (rnd_in) begin
      rd_data_a_i <= 24'($urandom);
      rd_data_b_i <= 24'($urandom);
      tw_data_i   <= 23'($urandom);
      rnd_a       <= 23'($urandom);
      rnd_b       <= 23'($urandom);
    end else begin
      if (rd_en_o) begin
        rd_data_a_i <= mem[rd_addr_a_o];
        rd_data_b_i <= mem[rd_addr_b_o];
      end
      tw_data_i <= {15'd0, tw_addr_o};
    end
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 24'(i);
    end else if (wr_en_o) begin
      mem[wr_addr_a_o] <= wr_data_a_o;
      mem[wr_addr_b_o] <= wr_data_b_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {busy_o, done_o, rd_en_o, wr_en_o, bf_sel_red_o, bf_sel_butterfly_o}, 0);
    check({tag, "_addr"}, {rd_addr_a_o, rd_addr_b_o, tw_addr_o, wr_addr_a_o, wr_addr_b_o}, 0);
    check({tag, "_wdata"}, {wr_data_a_o, wr_data_b_o}, 0);
    check({tag, "_bf"}, {bf_a_o, bf_b_o}, 0);
    check({tag, "_bftw"}, bf_twiddle_o, 0);
  endtask

  // Reference loop nest: k advances once per butterfly group and carries across layers.
  task automatic sb_push(input logic m, input logic s);
    int k;
    if (!m) begin
      k = 1;
      for (int len = 128; len >= (s ? 2 : 1); len = len / 2) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) q_exp.push_back({8'(j), 8'(j + len), 8'(k)});
          k++;
        end
      end
    end else begin
      k = s ? 127 : 255;
      for (int len = (s ? 2 : 1); len <= 128; len = len * 2) begin
        for (int st = 0; st < 256; st += 2 * len) begin
          for (int j = st; j < st + len; j++) q_exp.push_back({8'(j), 8'(j + len), 8'(k)});
          k--;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mc = edge_n - t0;
      if (rd_en_o) begin
        if (q_exp.size() == 0) begin
          check("rd_extra", 1, 0);
        end else begin
          exp_e = q_exp.pop_front();
          check("rd_seq", {rd_addr_a_o, rd_addr_b_o, tw_addr_o}, exp_e);
        end
        if (done_seen > 0 && rd2_cyc < 0) rd2_cyc = mc;
      end
      if (wr_en_o) begin
        if (first_chk && wr_cnt == 0) begin
          check("wr_addr0", {wr_addr_a_o, wr_addr_b_o}, {8'd0, 8'd128});
          check("wr_data0", {wr_data_a_o, wr_data_b_o}, {24'd1, 24'd130});
        end
        wr_cnt++;
        last_wr = mc;
        bit23 = bit23 | wr_data_a_o[23] | wr_data_b_o[23];
      end
      if (done_o) begin
        done_seen++;
        done_cyc = mc;
      end
      if (busy_o) busy_cnt++;
      foreach (spot_cyc[i]) begin
        if (spot_cyc[i] == mc) check("spot", {rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o}, spot_val[i]);
      end
    end
  end

  task automatic run_xform(input logic m, input logic s, input int exp_done, input int exp_wr,
                           input int poke, input bit b2b);
    int runs;
    runs = b2b ? 2 : 1;
    for (int r = 0; r < runs; r++) sb_push(m, s);
    wr_cnt = 0; done_seen = 0; busy_cnt = 0; bit23 = 1'b0;
    rd2_cyc = -1; last_wr = -1; done_cyc = -1;
    @(negedge clk); preload = 1'b1;
    @(negedge clk); preload = 1'b0;
    @(negedge clk);
    mode_i = m; sel_red_i = s; start_i = 1'b1; t0 = edge_n; mon_on = 1'b1;
    @(negedge clk);
    if (!b2b) start_i = 1'b0;
    for (int i = 0; i < 2500 && done_seen < runs; i++) begin
      @(negedge clk);
      if (poke > 0 && edge_n - t0 == poke) begin
        start_i = 1'b1; mode_i = ~m; sel_red_i = ~s;
      end else if (poke > 0 && edge_n - t0 == poke + 8) begin
        start_i = 1'b0; mode_i = m; sel_red_i = s;
      end
      if (b2b && edge_n - t0 == exp_done + 2) start_i = 1'b0;
    end
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    check("done_cyc", done_cyc, b2b ? (2 * exp_done + 1) : exp_done);
    check("wr_count", wr_cnt, exp_wr * runs);
    check("last_wr", last_wr, (b2b ? (2 * exp_done + 1) : exp_done) - 1);
    check("busy_cycles", busy_cnt, exp_done * runs);
    check("sb_left", q_exp.size(), 0);
    check("wr_bit23", bit23, 0);
    check("idle_after", {busy_o, rd_en_o, wr_en_o, done_o}, 0);
    if (b2b) check("b2b_first_rd", rd2_cyc, exp_done + 2);
    q_exp.delete();
    spot_cyc.delete();
    spot_val.delete();
  endtask

  task automatic mid_reset();
    logic any;
    @(negedge clk);
    mode_i = 1'b0; sel_red_i = 1'b0; start_i = 1'b1; t0 = edge_n;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 400 && (edge_n - t0) != 300; i++) @(negedge clk);
    check("midrun_active", {busy_o, rd_en_o, wr_en_o}, 3'b111);
    rst_ni = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      any = any | wr_en_o | rd_en_o | busy_o;
    end
    check("post_rst_quiet", any, 0);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; sel_red_i = 1'b0;
    rnd_in = 1'b1; mon_on = 1'b0; preload = 1'b0; first_chk = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start_i = 1'($urandom); mode_i = 1'($urandom); sel_red_i = 1'($urandom);
      #1;
      check_zero("rst");
    end
    @(negedge clk);
    rnd_in = 1'b0; start_i = 1'b0; mode_i = 1'b0; sel_red_i = 1'b0; rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Dilithium forward, with a start/mode poke while busy at cycle 500.
    spot_cyc = '{1, 129, 130, 194};
    spot_val = '{{1'b1, 8'd0, 8'd128, 8'd1}, 25'd0,
                 {1'b1, 8'd0, 8'd64, 8'd2}, {1'b1, 8'd128, 8'd192, 8'd3}};
    first_chk = 1'b1;
    run_xform(1'b0, 1'b0, 1033, 1024, 500, 1'b0);
    first_chk = 1'b0;
    check("sel_latched_fwd", {bf_sel_butterfly_o, bf_sel_red_o}, 2'b00);

    // Kyber inverse.
    spot_cyc = '{1, 2, 3, 775, 903};
    spot_val = '{{1'b1, 8'd0, 8'd2, 8'd127}, {1'b1, 8'd1, 8'd3, 8'd127},
                 {1'b1, 8'd4, 8'd6, 8'd126}, {1'b1, 8'd0, 8'd128, 8'd1}, 25'd0};
    run_xform(1'b1, 1'b1, 904, 896, 0, 1'b0);
    check("sel_latched_inv", {bf_sel_butterfly_o, bf_sel_red_o}, 2'b11);

    run_xform(1'b1, 1'b0, 1033, 1024, 0, 1'b0);
    run_xform(1'b0, 1'b1, 904, 896, 0, 1'b0);

    mid_reset();
    run_xform(1'b0, 1'b0, 1033, 1024, 0, 1'b0);

    // Start held high: two back-to-back Kyber inverse transforms.
    run_xform(1'b1, 1'b1, 904, 896, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
